// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, controller states, opcode width.
package alu_pkg;

    localparam int unsigned OpWidth = 3;

    typedef enum logic [OpWidth-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: start loads operands, done pulses on the WIDTH-th step.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] step_sum;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q;

    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // The final step is folded into the output so the product lands on the WIDTH-th edge.
    assign done    = busy_q && (cnt_q == CntW'(1));
    assign product = step_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CntW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 111; otherwise it reports err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [OpWidth-1:0] sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_n,
    output logic               err,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned ShW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             z_q, c_q, v_q, n_q, err_q, out_valid_q;

    op_e              op;
    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;

    assign op       = op_e'(sel);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul = (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_mul),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shamt   = b[ShW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // diff[WIDTH] is the borrow, i.e. a < b unsigned.
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << shamt;
            OP_SHR:  alu_res = a >> shamt;
            OP_MUL: begin
`ifndef ALU_MUL_EN
                alu_err = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept && is_mul) begin
`ifdef ALU_MUL_EN
                        state_q <= BUSY;
`endif
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= alu_res;
                        result_hi_q <= '0;
                        z_q         <= (alu_res == '0) && !alu_err;
                        c_q         <= alu_c;
                        v_q         <= alu_v;
                        n_q         <= alu_res[WIDTH-1];
                        err_q       <= alu_err;
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                BUSY: begin
                    if (mul_done) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_prod[WIDTH-1:0];
                        result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
                        z_q         <= (mul_prod == '0);
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                        n_q         <= mul_prod[WIDTH-1];
                        err_q       <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign flag_n    = n_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=4): driver pushes model results, negedge monitor pops/compares.
module tb_alu_seq;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic [2:0]   sel;
    logic         in_valid, in_ready;
    logic [W-1:0] result, result_hi;
    logic         flag_z, flag_c, flag_v, flag_n, err, out_valid, out_ready;

    typedef struct {
        logic [3:0] res;
        logic [3:0] hi;
        logic       z, c, v, n, err;
        int         acc_cyc;
        int         edges;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   xfer_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;
    bit   bp_en = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .result_hi(result_hi),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .flag_n   (flag_n),
        .err      (err),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input int ia, input int ib, input int isel);
        exp_t e;
        int   sa, sb, s, r, p;
        e  = '{default: 0};
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        r  = 0;
        case (isel)
            0: begin s = ia + ib; r = s % 16; e.c = (s > 15); s = sa + sb; e.v = (s > 7 || s < -8); end
            1: begin r = (ia - ib + 16) % 16; e.c = (ia < ib); s = sa - sb; e.v = (s > 7 || s < -8); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: r = (ia << (ib % 4)) % 16;
            6: r = ia >> (ib % 4);
            default: begin
`ifdef ALU_MUL_EN
                p = ia * ib;
                r = p % 16;
                e.hi = 4'(p / 16);
                e.edges = 4;
`else
                p = -1;
                e.err = 1'b1;
`endif
            end
        endcase
        e.res = 4'(r);
        if (isel != 7) begin
            e.z = (r == 0);
            e.n = (r >= 8);
        end else if (p >= 0) begin
            e.z = (p == 0);
            e.n = (r >= 8);
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input int ia, input int ib, input int isel);
        int   n;
        exp_t e;
        n = 0;
        a = 4'(ia);
        b = 4'(ib);
        sel = 3'(isel);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e = model(ia, ib, isel);
                e.acc_cyc = cyc + 1;
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL issue_timeout: in_ready stuck low, sel=%0d", isel);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: result=%0h with no pending op", result);
            end else begin
                mon_e = exp_q[0];
                if (!seen) begin
                    chk("latency", cyc - mon_e.acc_cyc, mon_e.edges);
                    seen = 1'b1;
                end
                chk("out{res,hi,z,c,v,n,err}",
                    {result, result_hi, flag_z, flag_c, flag_v, flag_n, err},
                    {mon_e.res, mon_e.hi, mon_e.z, mon_e.c, mon_e.v, mon_e.n, mon_e.err});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                    xfer_cyc.push_back(cyc);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        rst_n = 1'b0;
        a = '0;
        b = '0;
        sel = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {result, result_hi, flag_z, flag_c, flag_v, flag_n, err, out_valid}, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed ops.
        issue(6, 9, 0);
        @(negedge clk);
        chk("add_0110_1001", {result, flag_c, flag_v, flag_n, flag_z}, {4'b1111, 4'b0010});
        @(posedge clk);
        #1;
        issue(9, 13, 1);
        issue(5, 2, 2);
        @(negedge clk);
        chk("and_zero_flag", {result, flag_z}, {4'b0000, 1'b1});
        @(posedge clk);
        #1;
        issue(7, 6, 7);
`ifdef ALU_MUL_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", in_ready, 0);
        end
        @(negedge clk);
        chk("mul_0111_0110", {out_valid, result, result_hi}, {1'b1, 4'b1010, 4'b0010});
`else
        @(negedge clk);
        chk("mul_disabled", {out_valid, result, result_hi, err}, {1'b1, 8'h00, 1'b1});
`endif
        @(posedge clk);
        #1;

        // Backpressure: result held, competing input ignored, then accept on release edge.
        out_ready = 1'b0;
        issue(10, 10, 3);
        a = 4'd1;
        b = 4'd1;
        sel = 3'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {in_ready, out_valid, result}, {1'b0, 1'b1, 4'b1010});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(1, 1, 0);
        @(negedge clk);
        chk("bp_release_accept", {out_valid, result}, {1'b1, 4'b0010});
        repeat (3) @(posedge clk);
        #1;

        // Streaming: one result per clock.
        xfer_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 6));
        end
        repeat (3) @(negedge clk);
        chk("stream_count", xfer_cyc.size(), 8);
        if (xfer_cyc.size() >= 8) chk("stream_no_bubbles", xfer_cyc[7] - xfer_cyc[0], 7);
        @(posedge clk);
        #1;

        // Reset during the multiplier's second step.
        issue(7, 6, 7);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_mul", {result, result_hi, flag_z, flag_c, flag_v, flag_n, err, out_valid,
                                in_ready}, 1);
        end
        @(posedge clk);
        #1;

        // Randomised mix with random consumer backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
        end
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
        chk("idle_after_drain", {out_valid, in_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Operands are accepted through a valid/ready input interface and results are returned through a registered valid/ready output with status flags. Single-cycle ops complete in one clock; multiply is iterative shift-add over WIDTH clocks. The block sits between an operand-issue stage and a result consumer that may apply backpressure.

## Interface
- WIDTH, 4: operand and result width, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept
- result  out  WIDTH  result (MUL: low half of product)
- result_hi  out  WIDTH  MUL high half; 0 for other ops
- flag_z  out  1  result == 0 (MUL: whole product == 0)
- flag_c  out  1  ADD carry-out; SUB borrow (a < b unsigned); 0 otherwise
- flag_v  out  1  signed overflow for ADD/SUB; 0 otherwise
- flag_n  out  1  result[WIDTH-1]
- err  out  1  opcode not supported in this build
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: latch a, b, sel. Non-MUL → compute, register outputs, go DONE. MUL → go BUSY, start multiplier.
- BUSY: in_ready=0; one shift-add step per clock, WIDTH steps; then register product and flags, go DONE.
- DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready: if in_valid also high, accept new operation (same as IDLE accept); else go IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational on out_ready.
- Arithmetic modulo 2^WIDTH; shifts are logical, amount = b[$clog2(WIDTH)-1:0], vacated bits 0.
- Inputs ignored while in_ready=0.
- Reset (any state, including mid-BUSY): state IDLE, result/result_hi 0, all flags 0, err 0, out_valid 0, multiplier cleared; in-flight operation discarded.

## Timing
- Non-MUL: accept at edge N → out_valid high after edge N (latency 1).
- MUL: accept at edge N → out_valid high after edge N+WIDTH.
- Back-to-back non-MUL with out_ready held high: one result per clock.
- Outputs change only on clock edges when a new result is registered or reset occurs.

## Configuration
- ALU_MUL_EN defined: MUL implemented as above.
- ALU_MUL_EN undefined: no multiplier logic or BUSY state; opcode 111 completes in 1 cycle with result=0, result_hi=0, flags 0, err=1. err is 0 for all other opcodes in both builds.

## Structure
- Package alu_pkg: opcode enum (OP_ADD…OP_MUL), state enum (IDLE/BUSY/DONE), opcode width constant.
- Sub-module alu_mul_iter (WIDTH): start, a, b → done pulse, 2·WIDTH product; instantiated only under ALU_MUL_EN.

## Test plan
- WIDTH=4, ADD a=0110 b=1001, out_ready=1 → next cycle result=1111, c=0, v=0, n=1, z=0.
- SUB a=1001 b=1101 → result=1100, c=1, n=1, v=0; AND a=0101 b=0010 → result=0000, z=1.
- MUL a=0111 b=0110 (ALU_MUL_EN) → in_ready=0 for 4 cycles, out_valid after edge N+4, result=1010, result_hi=0010; without macro → 1-cycle result 0, err=1.
- Backpressure: OR a=1010 b=1010 with out_ready=0 for 5 cycles → result=1010 held, in_ready=0, new in_valid ignored; raise out_ready with in_valid → new op accepted same edge.
- Streaming: 8 random non-MUL ops, in_valid and out_ready held high → 8 consecutive correct results, no bubbles, matched against reference model.
- Reset mid-MUL: rst_n low 1 cycle at BUSY step 2 → all outputs 0, state IDLE, in_ready=1 next cycle; no stale out_valid.
